// File: rtl/ks_sched_pkg.sv
// Shared types and sizing for the multi-word add scheduler.
// Default slice geometry: 4-bit slice, 4 words, 16-bit operands.
package ks_sched_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The word counter stays at least one bit wide so WORDS=1 still has a legal vector.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int W     = DEF_N * DEF_WORDS;
  localparam int CNT_W = cnt_width(DEF_WORDS);

endpackage

// File: rtl/ks_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from valid and en.
// The pointer flips only when both requesters contend while enabled.
module ks_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic rr_ptr;
  logic both;

  assign both = valid[0] & valid[1];

  always_comb begin
    grant    = 2'b00;
    grant[0] = en & valid[0] & (~valid[1] | ~rr_ptr);
    grant[1] = en & valid[1] & (~valid[0] |  rr_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (en && both) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/ks_multiword_add_sched.sv
// Time-shares one N-bit combinational adder slice between two requesters,
// walking each N*WORDS-bit addition one word per cycle with a registered carry.
module ks_multiword_add_sched
  import ks_sched_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [N*WORDS-1:0] req0_a,
  input  logic [N*WORDS-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [N*WORDS-1:0] req1_a,
  input  logic [N*WORDS-1:0] req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [N*WORDS-1:0] rsp_sum,
  output logic               rsp_cout,
  output logic [N-1:0]       add_a,
  output logic [N-1:0]       add_b,
  output logic               add_cin,
  input  logic [N-1:0]       add_sum,
  input  logic               add_cout
);

  localparam int TCNT_W = cnt_width(WORDS);
  localparam logic [TCNT_W-1:0] LAST_CNT = TCNT_W'(WORDS - 1);

  state_t                      state;
  logic [TCNT_W-1:0]           cnt;
  logic                        carry;
  logic                        id_q;
  logic                        cout_q;
  logic [WORDS-1:0][N-1:0]     op_a;
  logic [WORDS-1:0][N-1:0]     op_b;
  logic [WORDS-1:0][N-1:0]     res;

  logic [1:0] arb_valid;
  logic [1:0] grant;
  logic       arb_en;
  logic       accept;

  // Gating on rst_n keeps ready low while reset is held, not just after it.
  assign arb_valid = {req1_valid, req0_valid};
  assign arb_en    = (state == IDLE) && rst_n;
  assign accept    = |grant;

  ks_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (arb_valid),
    .en    (arb_en),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = op_a[cnt];
      add_b   = op_b[cnt];
      add_cin = (cnt != '0) && carry;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = res;
  assign rsp_cout  = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      id_q   <= 1'b0;
      cout_q <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= grant[1] ? req1_a : req0_a;
            op_b  <= grant[1] ? req1_b : req0_b;
            id_q  <= grant[1];
            cnt   <= '0;
            carry <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          res[cnt] <= add_sum;
          carry    <= add_cout;
          if (cnt == LAST_CNT) begin
            cout_q <= add_cout;
            cnt    <= '0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Internal sanity properties.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_sum) && $stable(rsp_id) && $stable(rsp_cout)));
  a_no_grant_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> (grant == 2'b00));

endmodule

// File: tb/tb_ks_multiword_add_sched.sv
// Directed bench for ks_multiword_add_sched with a behavioural 4-bit adder slice.
module tb_ks_multiword_add_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_cout;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  ks_multiword_add_sched #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge; the response is consumed with rsp_ready=1.
  task automatic do_op(input logic sel, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] sum, output logic cout, output logic id,
                       output int lat, output logic [3:0] cins);
    int n;
    if (sel) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    n = 0;
    while (!(sel ? req1_ready : req0_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat  = 0;
    cins = '0;
    while (!rsp_valid && lat < 50) begin
      if (lat < 4) cins[lat] = add_cin;
      @(posedge clk); #1; lat++;
    end
    sum  = rsp_sum;
    cout = rsp_cout;
    id   = rsp_id;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  cins;
  } vec_t;

  vec_t vecs[6];

  logic [15:0] r_sum;
  logic        r_cout, r_id;
  int          r_lat;
  logic [3:0]  r_cins;
  int          acc_n, rsp_n, n;
  logic        acc_id[3];
  int          acc_cyc[3];
  logic        rid_q[3];
  logic [15:0] rsum_q[3];

  initial begin
    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4'b1110};
    vecs[1] = '{1'b1, 16'h1234, 16'h4321, 16'h5555, 1'b0, 4'b0000};
    vecs[2] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 4'b0000};
    vecs[3] = '{1'b1, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 4'b1110};
    vecs[4] = '{1'b0, 16'hABCD, 16'h5433, 16'h0000, 1'b1, 4'b1110};
    vecs[5] = '{1'b1, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 4'b1110};

    // Reset state, with both requesters already asking.
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0020;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'(0));
    chk("rst_req1_ready", 32'(req1_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_sum", 32'(rsp_sum), 32'(0));
    chk("rst_add_a", 32'(add_a), 32'(0));

    // Contention straight out of reset.
    rst_n = 1'b1;
    #1;
    acc_n = 0;
    rsp_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (req0_ready || req1_ready) begin
        if (acc_n < 3) begin acc_id[acc_n] = req1_ready; acc_cyc[acc_n] = cyc; end
        acc_n++;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_n < 3) begin rid_q[rsp_n] = rsp_id; rsum_q[rsp_n] = rsp_sum; end
        rsp_n++;
      end
      @(posedge clk); #1;
      if (acc_n >= 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("cont_accepts", 32'(acc_n), 32'(3));
    chk("cont_rsps", 32'(rsp_n), 32'(3));
    if (acc_n >= 3 && rsp_n >= 3) begin
      chk("cont_acc_id0", 32'(acc_id[0]), 32'(0));
      chk("cont_acc_id1", 32'(acc_id[1]), 32'(1));
      chk("cont_acc_id2", 32'(acc_id[2]), 32'(0));
      chk("cont_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(6));
      chk("cont_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(6));
      chk("cont_rsp_id0", 32'(rid_q[0]), 32'(0));
      chk("cont_rsp_id1", 32'(rid_q[1]), 32'(1));
      chk("cont_rsp_id2", 32'(rid_q[2]), 32'(0));
      chk("cont_rsp_sum0", 32'(rsum_q[0]), 32'h0003);
      chk("cont_rsp_sum1", 32'(rsum_q[1]), 32'h0030);
    end

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, r_sum, r_cout, r_id, r_lat, r_cins);
      chk($sformatf("vec%0d_sum", i), 32'(r_sum), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(r_cout), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_id", i), 32'(r_id), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_latency", i), 32'(r_lat), 32'(4));
      chk($sformatf("vec%0d_cins", i), 32'(r_cins), 32'(vecs[i].cins));
    end

    // Backpressure in RESP.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F01;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'(1));
    req1_valid = 1'b1; req1_a = 16'h1111; req1_b = 16'h2222;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'(1));
      chk($sformatf("bp_sum%0d", k), 32'(rsp_sum), 32'h1000);
      chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'(0));
      chk($sformatf("bp_ready%0d", k), 32'({req1_ready, req0_ready}), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'(0));
    chk("bp_release_ready1", 32'(req1_ready), 32'(1));
    req1_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while in RUN at word 2.
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_add_a_nonzero", 32'(add_a != 4'h0), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_rsp_sum", 32'(rsp_sum), 32'(0));
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("mid_rst_rsp_cout", 32'(rsp_cout), 32'(0));
    chk("mid_rst_add", 32'({add_a, add_b, add_cin}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 16'h8000, 16'h8000, r_sum, r_cout, r_id, r_lat, r_cins);
    chk("post_rst_sum", 32'(r_sum), 32'h0000);
    chk("post_rst_cout", 32'(r_cout), 32'(1));
    chk("post_rst_id", 32'(r_id), 32'(0));
    chk("post_rst_latency", 32'(r_lat), 32'(4));
    chk("post_rst_cins", 32'(r_cins), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
